// File: rtl/rob_retire.sv
// rob_retire: reorder buffer with out-of-order completion and in-order, one-per-cycle retire.
module rob_retire #(
    parameter int DEPTH    = 8,
    parameter int ADDR_W   = $clog2(DEPTH),
    parameter int D_ADDR_W = 3,
    parameter int D_DATA_W = 8,
    parameter int S_ADDR_W = 2,
    parameter int S_DATA_W = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                alloc_req,
    output logic                alloc_ready,
    output logic [ADDR_W-1:0]   alloc_addr,
    input  logic                cpl_valid,
    input  logic [ADDR_W-1:0]   cpl_rob_addr,
    input  logic                cpl_d_valid,
    input  logic [D_ADDR_W-1:0] cpl_d_addr,
    input  logic [D_DATA_W-1:0] cpl_d_data,
    input  logic                cpl_s_valid,
    input  logic [S_ADDR_W-1:0] cpl_s_addr,
    input  logic [S_DATA_W-1:0] cpl_s_data,
    output logic                ret_valid,
    output logic [ADDR_W-1:0]   ret_rob_addr,
    output logic                ret_d_valid,
    output logic [D_ADDR_W-1:0] ret_d_addr,
    output logic [D_DATA_W-1:0] ret_d_data,
    output logic                ret_s_valid,
    output logic [S_ADDR_W-1:0] ret_s_addr,
    output logic [S_DATA_W-1:0] ret_s_data,
    output logic [ADDR_W:0]     count,
    output logic                cpl_err
);
    localparam logic [ADDR_W:0] one = 1;
    logic [ADDR_W:0]     head, tail;
    logic [DEPTH-1:0]    busy, done, d_v, s_v;
    logic [D_ADDR_W-1:0] d_a [DEPTH];
    logic [D_DATA_W-1:0] d_d [DEPTH];
    logic [S_ADDR_W-1:0] s_a [DEPTH];
    logic [S_DATA_W-1:0] s_d [DEPTH];
    logic [ADDR_W-1:0]   hidx, tidx;
    logic                full, alloc_fire, cpl_ok, ret_fire;
    always_comb begin
        hidx        = head[ADDR_W-1:0];
        tidx        = tail[ADDR_W-1:0];
        full        = (hidx == tidx) && (head[ADDR_W] != tail[ADDR_W]);
        alloc_ready = !full;
        alloc_addr  = tidx;
        count       = tail - head;
        alloc_fire  = alloc_req && !full;
        cpl_ok      = cpl_valid && busy[cpl_rob_addr] && !done[cpl_rob_addr];
        ret_fire    = busy[hidx] && done[hidx];
    end
    // payload needs no reset: it is only visible once its done bit is set
    always_ff @(posedge clk) begin
        if (cpl_ok) begin
            d_v[cpl_rob_addr] <= cpl_d_valid;
            d_a[cpl_rob_addr] <= cpl_d_addr;
            d_d[cpl_rob_addr] <= cpl_d_data;
            s_v[cpl_rob_addr] <= cpl_s_valid;
            s_a[cpl_rob_addr] <= cpl_s_addr;
            s_d[cpl_rob_addr] <= cpl_s_data;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head         <= '0;
            tail         <= '0;
            busy         <= '0;
            done         <= '0;
            ret_valid    <= 1'b0;
            ret_rob_addr <= '0;
            ret_d_valid  <= 1'b0;
            ret_d_addr   <= '0;
            ret_d_data   <= '0;
            ret_s_valid  <= 1'b0;
            ret_s_addr   <= '0;
            ret_s_data   <= '0;
            cpl_err      <= 1'b0;
        end else if (flush) begin
            head        <= '0;
            tail        <= '0;
            busy        <= '0;
            done        <= '0;
            ret_valid   <= 1'b0;
            ret_d_valid <= 1'b0;
            ret_s_valid <= 1'b0;
            cpl_err     <= 1'b0;
        end else begin
            ret_valid   <= ret_fire;
            ret_d_valid <= ret_fire && d_v[hidx];
            ret_s_valid <= ret_fire && s_v[hidx];
            cpl_err     <= cpl_valid && !cpl_ok;
            if (ret_fire) begin
                ret_rob_addr <= hidx;
                ret_d_addr   <= d_a[hidx];
                ret_d_data   <= d_d[hidx];
                ret_s_addr   <= s_a[hidx];
                ret_s_data   <= s_d[hidx];
                busy[hidx]   <= 1'b0;
                done[hidx]   <= 1'b0;
                head         <= head + one;
            end
            // a legal completion never targets a retiring head, since that head is already done
            if (cpl_ok) done[cpl_rob_addr] <= 1'b1;
            if (alloc_fire) begin
                busy[tidx] <= 1'b1;
                done[tidx] <= 1'b0;
                tail       <= tail + one;
            end
        end
    end
endmodule

// File: tb/tb_rob_retire.sv
// tb_rob_retire: scenario tasks plus random traffic against a program-order queue model of the ROB.
module tb_rob_retire;
    localparam int DEPTH = 8;
    logic       clk = 0, rst = 0, flush = 0, alloc_req = 0, cpl_valid = 0;
    logic       alloc_ready, ret_valid, ret_d_valid, ret_s_valid, cpl_err;
    logic [2:0] alloc_addr, cpl_rob_addr = 0, ret_rob_addr;
    logic       cpl_d_valid = 0, cpl_s_valid = 0;
    logic [2:0] cpl_d_addr = 0, ret_d_addr;
    logic [7:0] cpl_d_data = 0, ret_d_data;
    logic [1:0] cpl_s_addr = 0, ret_s_addr;
    logic       cpl_s_data = 0, ret_s_data;
    logic [3:0] count;
    int tests = 0, errors = 0;

    typedef struct {
        int         tag;
        bit         done;
        bit         dv;
        logic [2:0] da;
        logic [7:0] dd;
        bit         sv;
        logic [1:0] sa;
        logic       sd;
    } ent_t;
    ent_t q[$];
    ent_t last;
    int   next_tag;

    rob_retire dut (
        .clk(clk), .rst(rst), .flush(flush), .alloc_req(alloc_req), .alloc_ready(alloc_ready),
        .alloc_addr(alloc_addr), .cpl_valid(cpl_valid), .cpl_rob_addr(cpl_rob_addr),
        .cpl_d_valid(cpl_d_valid), .cpl_d_addr(cpl_d_addr), .cpl_d_data(cpl_d_data),
        .cpl_s_valid(cpl_s_valid), .cpl_s_addr(cpl_s_addr), .cpl_s_data(cpl_s_data),
        .ret_valid(ret_valid), .ret_rob_addr(ret_rob_addr), .ret_d_valid(ret_d_valid),
        .ret_d_addr(ret_d_addr), .ret_d_data(ret_d_data), .ret_s_valid(ret_s_valid),
        .ret_s_addr(ret_s_addr), .ret_s_data(ret_s_data), .count(count), .cpl_err(cpl_err)
    );

    always #5 clk = ~clk;

    task automatic model_clear();
        q.delete();
        next_tag = 0;
        last = '{default: 0};
    endtask

    // One clock of stimulus; the model advances by the same edge and the DUT is compared to it.
    task automatic drive_cycle(input bit al, input bit fl, input bit cv, input int tag,
                               input bit dv, input int da, input int dd,
                               input bit sv, input int sa, input int sd);
        int idx;
        bit exp_err, rf, was_full;
        ent_t r;
        tests++;
        if (alloc_ready !== (q.size() < DEPTH)) begin
            errors++;
            $display("FAIL alloc_ready: got %b want %b", alloc_ready, q.size() < DEPTH);
        end
        tests++;
        if (alloc_addr !== 3'(next_tag)) begin
            errors++;
            $display("FAIL alloc_addr: got %0d want %0d", alloc_addr, next_tag);
        end
        tests++;
        if (count !== 4'(q.size())) begin
            errors++;
            $display("FAIL count: got %0d want %0d", count, q.size());
        end
        alloc_req = al; flush = fl; cpl_valid = cv; cpl_rob_addr = 3'(tag);
        cpl_d_valid = dv; cpl_d_addr = 3'(da); cpl_d_data = 8'(dd);
        cpl_s_valid = sv; cpl_s_addr = 2'(sa); cpl_s_data = 1'(sd);
        exp_err = 0;
        rf = 0;
        if (fl) begin
            q.delete();
            next_tag = 0;
        end else begin
            was_full = (q.size() == DEPTH);
            idx = -1;
            foreach (q[i]) if (q[i].tag == tag) idx = i;
            exp_err = cv && (idx < 0 || q[idx].done);
            if (q.size() > 0 && q[0].done) begin
                rf = 1;
                r = q.pop_front();
                last = r;
            end
            if (cv && !exp_err) begin
                idx = idx - int'(rf);
                q[idx].done = 1;
                q[idx].dv = dv; q[idx].da = 3'(da); q[idx].dd = 8'(dd);
                q[idx].sv = sv; q[idx].sa = 2'(sa); q[idx].sd = 1'(sd);
            end
            if (al && !was_full) begin
                r = '{default: 0};
                r.tag = next_tag;
                q.push_back(r);
                next_tag = (next_tag + 1) % DEPTH;
            end
        end
        @(posedge clk);
        #1;
        alloc_req = 0; flush = 0; cpl_valid = 0;
        tests++;
        if (ret_valid !== rf || ret_d_valid !== (rf && last.dv) || ret_s_valid !== (rf && last.sv)) begin
            errors++;
            $display("FAIL ret_valids: got v=%b d=%b s=%b want v=%b d=%b s=%b",
                     ret_valid, ret_d_valid, ret_s_valid, rf, rf && last.dv, rf && last.sv);
        end
        tests++;
        if (ret_rob_addr !== 3'(last.tag) || ret_d_addr !== last.da || ret_d_data !== last.dd ||
            ret_s_addr !== last.sa || ret_s_data !== last.sd) begin
            errors++;
            $display("FAIL ret_payload: got tag=%0d da=%0d dd=%h sa=%0d sd=%b want tag=%0d da=%0d dd=%h sa=%0d sd=%b",
                     ret_rob_addr, ret_d_addr, ret_d_data, ret_s_addr, ret_s_data,
                     last.tag, last.da, last.dd, last.sa, last.sd);
        end
        tests++;
        if (cpl_err !== exp_err) begin
            errors++;
            $display("FAIL cpl_err: got %b want %b", cpl_err, exp_err);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic alloc_n(input int n);
        for (int i = 0; i < n; i++) drive_cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        rst = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 0;
        model_clear();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        tests++;
        if (alloc_ready !== 1'b1 || alloc_addr !== 3'd0 || count !== 4'd0 ||
            ret_valid !== 1'b0 || cpl_err !== 1'b0 || ret_d_data !== 8'd0) begin
            errors++;
            $display("FAIL reset_state: got rdy=%b addr=%0d cnt=%0d rv=%b err=%b dd=%h want 1 0 0 0 0 00",
                     alloc_ready, alloc_addr, count, ret_valid, cpl_err, ret_d_data);
        end
    endtask

    task automatic test_in_order();
        do_reset();
        alloc_n(3);
        tests++;
        if (count !== 4'd3) begin
            errors++;
            $display("FAIL inorder_count: got %0d want 3", count);
        end
        drive_cycle(0, 0, 1, 2, 1, 3, 'hA3, 0, 0, 0);
        drive_cycle(0, 0, 1, 0, 1, 1, 'hA1, 0, 0, 0);
        tests++;
        if (ret_valid !== 1'b0) begin
            errors++;
            $display("FAIL inorder_latency_early: got ret_valid=%b want 0", ret_valid);
        end
        drive_cycle(0, 0, 1, 1, 1, 2, 'hA2, 0, 0, 0);
        tests++;
        if (ret_valid !== 1'b1 || ret_rob_addr !== 3'd0 || ret_d_data !== 8'hA1) begin
            errors++;
            $display("FAIL inorder_first_retire: got v=%b tag=%0d dd=%h want 1 0 a1", ret_valid, ret_rob_addr, ret_d_data);
        end
        idle(4);
    endtask

    task automatic test_full();
        do_reset();
        alloc_n(9);
        tests++;
        if (alloc_ready !== 1'b0 || count !== 4'd8) begin
            errors++;
            $display("FAIL full_state: got rdy=%b cnt=%0d want 0 8", alloc_ready, count);
        end
        drive_cycle(1, 0, 1, 0, 1, 5, 'h5C, 0, 0, 0);
        drive_cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tests++;
        if (alloc_ready !== 1'b1 || alloc_addr !== 3'd0) begin
            errors++;
            $display("FAIL full_wrap: got rdy=%b addr=%0d want 1 0", alloc_ready, alloc_addr);
        end
        alloc_n(1);
        idle(1);
    endtask

    task automatic test_cpl_err();
        do_reset();
        drive_cycle(0, 0, 1, 5, 1, 1, 'h11, 0, 0, 0);
        tests++;
        if (cpl_err !== 1'b1) begin
            errors++;
            $display("FAIL err_unalloc: got %b want 1", cpl_err);
        end
        idle(1);
        alloc_n(1);
        drive_cycle(0, 0, 1, 0, 1, 6, 'h66, 0, 0, 0);
        drive_cycle(0, 0, 1, 0, 1, 7, 'h77, 1, 3, 1);
        tests++;
        if (cpl_err !== 1'b1 || ret_d_data !== 8'h66) begin
            errors++;
            $display("FAIL err_double: got err=%b dd=%h want 1 66", cpl_err, ret_d_data);
        end
        idle(2);
    endtask

    task automatic test_flush();
        do_reset();
        alloc_n(4);
        drive_cycle(0, 0, 1, 1, 1, 1, 'h21, 0, 0, 0);
        drive_cycle(1, 0, 1, 3, 1, 3, 'h23, 0, 0, 0);
        drive_cycle(1, 1, 1, 0, 1, 2, 'h99, 0, 0, 0);
        tests++;
        if (count !== 4'd0 || alloc_addr !== 3'd0) begin
            errors++;
            $display("FAIL flush_state: got cnt=%0d addr=%0d want 0 0", count, alloc_addr);
        end
        idle(3);
    endtask

    task automatic test_s_only();
        do_reset();
        alloc_n(1);
        drive_cycle(0, 0, 1, 0, 0, 4, 'h44, 1, 2, 1);
        drive_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tests++;
        if (ret_valid !== 1'b1 || ret_d_valid !== 1'b0 || ret_s_valid !== 1'b1 || ret_s_addr !== 2'd2) begin
            errors++;
            $display("FAIL s_only: got v=%b d=%b s=%b sa=%0d want 1 0 1 2", ret_valid, ret_d_valid, ret_s_valid, ret_s_addr);
        end
        idle(1);
    endtask

    task automatic test_async_reset();
        do_reset();
        alloc_n(5);
        drive_cycle(0, 0, 1, 0, 1, 1, 'h31, 0, 0, 0);
        drive_cycle(0, 0, 1, 1, 1, 2, 'h32, 0, 0, 0);
        #2;
        rst = 1;
        #1;
        tests++;
        if (alloc_ready !== 1'b1 || count !== 4'd0 || ret_valid !== 1'b0 || ret_rob_addr !== 3'd0) begin
            errors++;
            $display("FAIL async_reset: got rdy=%b cnt=%0d rv=%b tag=%0d want 1 0 0 0",
                     alloc_ready, count, ret_valid, ret_rob_addr);
        end
        @(negedge clk);
        rst = 0;
        model_clear();
        @(posedge clk);
        #1;
        idle(2);
    endtask

    task automatic test_random();
        int tag;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            tag = (q.size() > 0 && $urandom_range(0, 7) != 0) ? q[$urandom_range(0, q.size() - 1)].tag
                                                               : int'($urandom_range(0, 7));
            drive_cycle($urandom_range(0, 3) != 0, $urandom_range(0, 63) == 0, $urandom_range(0, 1) == 1, tag,
                        $urandom_range(0, 1) == 1, $urandom_range(0, 7), $urandom_range(0, 255),
                        $urandom_range(0, 1) == 1, $urandom_range(0, 3), $urandom_range(0, 1));
        end
        idle(10);
    endtask

    initial begin
        test_reset();
        test_in_order();
        test_full();
        test_cpl_err();
        test_flush();
        test_s_only();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end
endmodule

// File: doc/rob_retire.md
Name: rob_retire

Overview:
- Reorder buffer and in-order retire stage of the out-of-order NAND CPU.
- Allocates a ROB tag per dispatched instruction and accepts out-of-order completions from the e_a2c pipeline register.
- Holds completed register-file writes until their entry reaches the head.
- Releases one entry per cycle, in program order, as architectural D- and S-regfile writes.

Parameters:
- DEPTH, 8, number of ROB entries; power of two, at least 2.
- ADDR_W, $clog2(DEPTH), ROB tag width.
- D_ADDR_W, 3, D-regfile address width.
- D_DATA_W, 8, D-regfile data width.
- S_ADDR_W, 2, S-regfile address width.
- S_DATA_W, 1, S-regfile data width.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous squash of all entries.
- alloc_req  in  1  dispatch requests a tag.
- alloc_ready  out  1  ROB not full.
- alloc_addr  out  ADDR_W  tag granted on alloc_req && alloc_ready.
- cpl_valid  in  1  completion from e_a2c (md_out.valid).
- cpl_rob_addr  in  ADDR_W  completing tag.
- cpl_d_valid, cpl_d_addr, cpl_d_data  in  1/D_ADDR_W/D_DATA_W  D write carried by the instruction.
- cpl_s_valid, cpl_s_addr, cpl_s_data  in  1/S_ADDR_W/S_DATA_W  S write carried by the instruction.
- ret_valid  out  1  one instruction retired.
- ret_rob_addr  out  ADDR_W  tag retired.
- ret_d_valid, ret_d_addr, ret_d_data  out  1/D_ADDR_W/D_DATA_W  architectural D write.
- ret_s_valid, ret_s_addr, ret_s_data  out  1/S_ADDR_W/S_DATA_W  architectural S write.
- count  out  ADDR_W+1  occupied entries.
- cpl_err  out  1  one-cycle pulse on an illegal completion.

Behaviour:
- Reset: clk is the single clock. rst is asynchronous and active-high.
  - Clears head, tail, all per-entry busy/done bits and all ret_* outputs, count and cpl_err.
  - After reset: alloc_ready=1, alloc_addr=0.
  - Reset asserted mid-operation discards every entry immediately. No retire output follows.
- Pointers: head and tail are ADDR_W+1 bits wide; the extra bit is a wrap bit.
  - empty: head==tail.
  - full: the low bits are equal and the wrap bits differ.
  - alloc_addr = tail[ADDR_W-1:0].
  - alloc_ready = !full, combinational from state only.
  - count = tail-head, modulo 2^(ADDR_W+1).
- Allocate: when alloc_req && alloc_ready, entry[tail] gets busy=1, done=0, and tail increments (wrapping naturally).
  - alloc_req while full is ignored; the requester holds it.
  - Allocation does not see a same-cycle retire; a full ROB stays not-ready that cycle.
- Complete: when cpl_valid, entry[cpl_rob_addr] stores the d/s valid, address and data, and sets done=1.
  - If the entry is not busy, or is already done, the completion is dropped and cpl_err pulses in the next cycle.
  - A completion may target any busy entry, in any order.
- Retire: evaluated on registered state each cycle.
  - If entry[head] is busy && done, on the edge: ret_valid=1, ret_rob_addr=head, ret_d_*/ret_s_* = the stored values. The entry is cleared and head increments.
  - Otherwise ret_valid, ret_d_valid and ret_s_valid are 0; the addr/data outputs hold their previous values.
  - ret_d_valid/ret_s_valid are only asserted together with ret_valid.
  - At most one retire per cycle.
- Latency: a completion presented in cycle c to the head entry produces ret_valid in cycle c+2.
- Simultaneous events in one cycle: allocate, complete (to a different entry) and retire are all legal and independent.
  - count reflects the net change.
  - Allocate and retire together while full is not possible, since alloc_ready=0.
- Flush: synchronous and highest priority.
  - On the edge: head=tail=0, all busy/done cleared, ret_* valids 0, cpl_err 0.
  - alloc_req/cpl_valid in the flush cycle are ignored, and no retire occurs that cycle.
- Widths: all pointer arithmetic is modulo 2^(ADDR_W+1); no saturation.

Test Plan:
- Reset release, then 3 allocs → alloc_addr 0,1,2 and count=3. Complete tags 2,0,1 in consecutive cycles with d writes (addr 1..3, data 0xA1..0xA3) → retires in order tag 0,1,2; the first ret_valid is 2 cycles after tag 0 completes.
- Allocate 8 with no completions → alloc_ready=0 and count=8; a 9th alloc_req is ignored. Complete tag 0 → it retires, alloc_ready=1, and the next alloc_addr=0 (wrap).
- Complete tag 5 while it is not allocated → cpl_err pulses for one cycle; state unchanged. Complete the same busy tag twice → the second completion raises cpl_err and the first payload retires.
- 4 busy entries, 2 of them done; assert flush → count=0, no ret_valid afterwards, and alloc_addr=0 next cycle.
- Completion with cpl_d_valid=0, cpl_s_valid=1 (addr 2, data 1) → ret_valid=1, ret_d_valid=0, ret_s_valid=1, ret_s_addr=2.
- Assert rst asynchronously mid-stream with 5 entries → outputs cleared without waiting for a clk edge; alloc_ready=1 and count=0.
